alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
Parametrised, registered successor to the combinational 8-bit ALU, used as the processor datapath ALU.
- Width is a parameter W.
- Opcode field widened to 4 bits.
- Adds carry-chained add/subtract (ADC/SBC), multi-bit barrel shifts, rotate-through-carry, and an iterative W-cycle unsigned multiply with a 2W-bit result.
- Results and flags are registered. A Start/Busy/Done handshake lets the control unit stall on multi-cycle ops.

Parameters:
- W, 8, data width in bits (W >= 4, power of two).
- SW, $clog2(W), shift-amount width (derived; do not override).

Ports:
- Clk  in  1  clock, all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  request an operation; accepted only when Busy=0.
- OP  in  4  opcode (op_mne_e), sampled with Start.
- InputA  in  W  operand A (accumulator side), sampled with Start.
- InputB  in  W  operand B, sampled with Start.
- Out  out  W  result low word, registered.
- OutHi  out  W  MUL high word; 0 after any non-MUL op.
- Busy  out  1  high while a MUL is iterating.
- Done  out  1  one-cycle pulse: Out/OutHi/flags updated this cycle.
- Illegal  out  1  one-cycle pulse with Done for an undefined opcode.
- Carry  out  1  registered carry/shift-out flag; also the carry-in for ADC/SBC/ROL.
- Zero  out  1  ~|Out (MUL: ~|{OutHi,Out}), registered.
- Parity  out  1  ^Out, registered.
- Odd  out  1  Out[0], registered.

Behaviour:
- Reset: Out=0, OutHi=0, Busy=0, Done=0, Illegal=0, Carry=0, Zero=1, Parity=0, Odd=0; FSM=IDLE; multiplier counter=0. Reset in mid-MUL aborts it; no Done is produced.
- FSM states: IDLE, MUL_RUN.
  - IDLE with Start and a single-cycle op: result written at this edge; Done=1 for the next cycle.
  - IDLE with Start and MUL: operands latched; counter=W; go to MUL_RUN; Busy=1 from the next cycle.
  - MUL_RUN: one shift-add step per cycle; counter decrements.
  - On the step where counter reaches 1: write the product, set Done=1 and Busy=0 for the next cycle, return to IDLE.
- Latency: single-cycle ops 1 cycle (Start edge to Done); MUL W cycles (Busy high for W-1 cycles, Done in cycle W).
- Start while Busy=1 is ignored (no queueing). Start in the same cycle as Done (FSM already IDLE) is accepted normally.
- Out, OutHi and flags change only on a Done edge and hold otherwise. Done never asserts on two consecutive cycles for one Start.
- Opcodes (flag rules unless noted: Carry=0, OutHi=0, Zero/Parity/Odd from Out):
  - 0 ADD: {Carry,Out} = A + B.
  - 1 ADC: {Carry,Out} = A + B + Carry.
  - 2 SUB: {Carry,Out} = B + ~A + 1, i.e. B - A; Carry=1 means no borrow.
  - 3 SBC: {Carry,Out} = B + ~A + Carry.
  - 4 AND: A & B.
  - 5 XOR: A ^ B.
  - 6 OR: A | B.
  - 7 MOVA: A.
  - 8 MOVB: B.
  - 9 LSL: n = B[SW-1:0]. Out = A << n. Carry = A[W-n] for n>0; Carry=0 for n=0.
  - 10 LSR: Out = A >> n. Carry = A[n-1] for n>0; 0 otherwise.
  - 11 ASR: arithmetic right shift by n, sign-filled. Carry as LSR.
  - 12 ROL: {Carry,Out} = {A, Carry} (rotate-left through carry, by 1).
  - 13 MUL: {OutHi,Out} = A * B, unsigned. Carry = |OutHi (overflow of the low word). Zero over 2W bits.
  - 14, 15: undefined. Out=A, Carry unchanged, flags from Out, Illegal=1 with Done.
- Arithmetic is W+1 bits internally; no X propagation on undefined opcodes.

Decomposition:
- Package Definitions gains:
  - op_mne_e, a 4-bit enum with the encodings above (ADD..MUL).
  - alu_state_e {IDLE, MUL_RUN}.
  - Localparam OP_W=4.
- Sub-module alu_seq_mul: iterative shift-add multiplier.
  - Ports: Clk, Reset, load, a, b, step, product[2W-1:0], last.
  - alu_seq owns the FSM and flag logic.

Test Plan (W=8):
- Reset held 2 cycles, then released -> Out=0x00, Zero=1, Carry=0, Busy=0, Done=0.
- ADD A=0xF0, B=0x20, then ADC A=0x01, B=0x00 -> Out=0x10 with Carry=1 and Done one cycle after Start; then Out=0x02, Carry=0.
- SUB A=0x05, B=0x03 -> Out=0xFE, Carry=0. Then SUB A=0x03, B=0x03 -> Out=0x00, Zero=1, Carry=1.
- Shifts on A=0x81:
  - LSL n=1 -> Out=0x02, Carry=1.
  - ASR n=3 -> Out=0xF0, Carry=0.
  - LSR n=0 -> Out=0x81, Carry=0.
  - ROL with Carry=1 -> Out=0x03, Carry=1.
- MUL A=0xFF, B=0xFF -> Busy high 7 cycles, Done in cycle 8: OutHi=0xFE, Out=0x01, Carry=1. A second Start mid-MUL is ignored.
- MUL A=0x12, B=0x34, Reset asserted at cycle 4 -> no Done; Out=0, OutHi=0, Busy=0 next cycle. OP=14 afterwards with A=0x55 -> Out=0x55, Illegal=1 with Done.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the registered sequential ALU.
// Contents: opcode width, opcode mnemonics (op_mne_e) and the control FSM
// state type (alu_state_e). Opcodes 14 and 15 are deliberately left unnamed.
package alu_seq_pkg;

  localparam int unsigned OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    ADD  = 4'd0,
    ADC  = 4'd1,
    SUB  = 4'd2,
    SBC  = 4'd3,
    AND  = 4'd4,
    XOR  = 4'd5,
    OR   = 4'd6,
    MOVA = 4'd7,
    MOVB = 4'd8,
    LSL  = 4'd9,
    LSR  = 4'd10,
    ASR  = 4'd11,
    ROL  = 4'd12,
    MUL  = 4'd13
  } op_mne_e;

  typedef enum logic {
    IDLE    = 1'b0,
    MUL_RUN = 1'b1
  } alu_state_e;

endpackage

// File: rtl/alu_seq_if.sv
// Request/result bundle between the control unit (master) and the ALU (slave).
// Request : Start, OP, InputA, InputB
// Result  : Out, OutHi, Busy, Done, Illegal, Carry, Zero, Parity, Odd
interface alu_seq_if
  import alu_seq_pkg::*;
#(
  parameter int unsigned W = 8
) ();

  logic            Start;
  logic [OP_W-1:0] OP;
  logic [W-1:0]    InputA;
  logic [W-1:0]    InputB;
  logic [W-1:0]    Out;
  logic [W-1:0]    OutHi;
  logic            Busy;
  logic            Done;
  logic            Illegal;
  logic            Carry;
  logic            Zero;
  logic            Parity;
  logic            Odd;

  modport master (
    output Start, OP, InputA, InputB,
    input  Out, OutHi, Busy, Done, Illegal, Carry, Zero, Parity, Odd
  );

  modport slave (
    input  Start, OP, InputA, InputB,
    output Out, OutHi, Busy, Done, Illegal, Carry, Zero, Parity, Odd
  );

endinterface

// File: rtl/alu_seq_mul.sv
// Iterative shift-add unsigned multiplier, one multiplier bit per cycle.
// Ports: Clk, Reset (sync, active-high); load latches a/b; step advances one
// bit; product is the partial product after the current step (combinational);
// last flags the step that completes the W-bit product.
module alu_seq_mul #(
  parameter int unsigned W = 8
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           load,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic           step,
  output logic [2*W-1:0] product,
  output logic           last
);

  localparam int unsigned CW = $clog2(W) + 1;

  logic [2*W-1:0] p_q;
  logic [W-1:0]   a_q;
  logic [CW-1:0]  cnt_q;

  // {acc_hi, multiplier_lo}: add multiplicand to the high half when the
  // current low bit is set, then shift the whole register right by one.
  function automatic logic [2*W-1:0] shift_add(input logic [2*W-1:0] p,
                                               input logic [W-1:0]   m);
    logic [W:0] hi;
    hi = {1'b0, p[2*W-1:W]} + (p[0] ? {1'b0, m} : '0);
    return {hi, p[W-1:1]};
  endfunction

  // The load edge already retires multiplier bit 0, so only W-1 further
  // steps are needed; the completing step is the one taking cnt from 2 to 1.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      p_q   <= '0;
      a_q   <= '0;
      cnt_q <= '0;
    end else if (load) begin
      p_q   <= shift_add({{W{1'b0}}, b}, a);
      a_q   <= a;
      cnt_q <= CW'(W);
    end else if (step) begin
      p_q   <= shift_add(p_q, a_q);
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign product = shift_add(p_q, a_q);
  assign last    = (cnt_q == CW'(2));

endmodule

// File: rtl/alu_seq.sv
// Registered W-bit datapath ALU with a Start/Busy/Done handshake.
// Ports: Clk, Reset (sync, active-high), bus (alu_seq_if.slave) carrying the
// request (Start, OP, InputA, InputB) and registered results/flags.
// Single-cycle ops complete on the Start edge; MUL iterates for W cycles.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned W  = 8,
  parameter int unsigned SW = $clog2(W)
) (
  input logic       Clk,
  input logic       Reset,
  alu_seq_if.slave  bus
);

  alu_state_e     state_q, state_d;
  logic [W-1:0]   out_q, out_d;
  logic [W-1:0]   hi_q, hi_d;
  logic           carry_q, carry_d;
  logic           zero_q, zero_d;
  logic           parity_q, parity_d;
  logic           odd_q, odd_d;
  logic           done_q, done_d;
  logic           ill_q, ill_d;

  op_mne_e        op;
  logic [W-1:0]   a, b;
  logic [SW-1:0]  n;
  logic [W:0]     shl, shr, asr;
  logic [W-1:0]   alu_res;
  logic           alu_c;
  logic           alu_ill;

  logic           mul_load, mul_step, mul_last;
  logic [2*W-1:0] prod;

  assign op = op_mne_e'(bus.OP);
  assign a  = bus.InputA;
  assign b  = bus.InputB;
  assign n  = b[SW-1:0];

  // Shifts are done one bit wider so the shifted-out bit lands in the spare
  // position; with n=0 that position holds the 0 pad, giving Carry=0.
  always_comb begin
    shl     = {1'b0, a} << n;
    shr     = {a, 1'b0} >> n;
    asr     = $unsigned($signed({a, 1'b0}) >>> n);
    alu_res = a;
    alu_c   = 1'b0;
    alu_ill = 1'b0;
    case (op)
      ADD:     {alu_c, alu_res} = {1'b0, a} + {1'b0, b};
      ADC:     {alu_c, alu_res} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, carry_q};
      SUB:     {alu_c, alu_res} = {1'b0, b} + {1'b0, ~a} + {{W{1'b0}}, 1'b1};
      SBC:     {alu_c, alu_res} = {1'b0, b} + {1'b0, ~a} + {{W{1'b0}}, carry_q};
      AND:     alu_res = a & b;
      XOR:     alu_res = a ^ b;
      OR:      alu_res = a | b;
      MOVA:    alu_res = a;
      MOVB:    alu_res = b;
      LSL:     {alu_c, alu_res} = shl;
      LSR:     {alu_res, alu_c} = shr;
      ASR:     {alu_res, alu_c} = asr;
      ROL:     {alu_c, alu_res} = {a, carry_q};
      MUL:     alu_res = a;
      default: begin
        alu_res = a;
        alu_c   = carry_q;
        alu_ill = 1'b1;
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    hi_d     = hi_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    parity_d = parity_q;
    odd_d    = odd_q;
    done_d   = 1'b0;
    ill_d    = 1'b0;
    mul_load = 1'b0;
    mul_step = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.Start) begin
          if (op == MUL) begin
            mul_load = 1'b1;
            state_d  = MUL_RUN;
          end else begin
            out_d    = alu_res;
            hi_d     = '0;
            carry_d  = alu_c;
            zero_d   = ~|alu_res;
            parity_d = ^alu_res;
            odd_d    = alu_res[0];
            done_d   = 1'b1;
            ill_d    = alu_ill;
          end
        end
      end
      MUL_RUN: begin
        mul_step = 1'b1;
        if (mul_last) begin
          out_d    = prod[W-1:0];
          hi_d     = prod[2*W-1:W];
          carry_d  = |prod[2*W-1:W];
          zero_d   = ~|prod;
          parity_d = ^prod[W-1:0];
          odd_d    = prod[0];
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      out_q    <= '0;
      hi_q     <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b1;
      parity_q <= 1'b0;
      odd_q    <= 1'b0;
      done_q   <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      hi_q     <= hi_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      parity_q <= parity_d;
      odd_q    <= odd_d;
      done_q   <= done_d;
      ill_q    <= ill_d;
    end
  end

  alu_seq_mul #(.W(W)) u_mul (
    .Clk     (Clk),
    .Reset   (Reset),
    .load    (mul_load),
    .a       (a),
    .b       (b),
    .step    (mul_step),
    .product (prod),
    .last    (mul_last)
  );

  assign bus.Out     = out_q;
  assign bus.OutHi   = hi_q;
  assign bus.Busy    = (state_q == MUL_RUN);
  assign bus.Done    = done_q;
  assign bus.Illegal = ill_q;
  assign bus.Carry   = carry_q;
  assign bus.Zero    = zero_q;
  assign bus.Parity  = parity_q;
  assign bus.Odd     = odd_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (W=8): directed cases with literal
// expectations, then randomized traffic against a behavioural model.
module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam int W    = 8;
  localparam int MASK = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_seq_if #(.W(W)) bus ();

  alu_seq #(.W(W)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model state: architectural registers plus remaining MUL cycles.
  int m_out = 0, m_hi = 0, m_c = 0, m_done = 0, m_ill = 0;
  int m_cnt = 0, m_prod = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_alu(input int op, input int a, input int b);
    int s, n, sa;
    n = b % W;
    m_hi = 0;
    case (op)
      0:  begin s = a + b;                    m_out = s & MASK; m_c = (s >> W) & 1; end
      1:  begin s = a + b + m_c;              m_out = s & MASK; m_c = (s >> W) & 1; end
      2:  begin s = b + (~a & MASK) + 1;      m_out = s & MASK; m_c = (s >> W) & 1; end
      3:  begin s = b + (~a & MASK) + m_c;    m_out = s & MASK; m_c = (s >> W) & 1; end
      4:  begin m_out = a & b; m_c = 0; end
      5:  begin m_out = a ^ b; m_c = 0; end
      6:  begin m_out = a | b; m_c = 0; end
      7:  begin m_out = a;     m_c = 0; end
      8:  begin m_out = b;     m_c = 0; end
      9:  begin m_out = (a << n) & MASK; m_c = (n == 0) ? 0 : (a >> (W - n)) & 1; end
      10: begin m_out = a >> n;          m_c = (n == 0) ? 0 : (a >> (n - 1)) & 1; end
      11: begin
        sa    = (a >= (1 << (W - 1))) ? a - (1 << W) : a;
        m_out = (sa >>> n) & MASK;
        m_c   = (n == 0) ? 0 : (a >> (n - 1)) & 1;
      end
      12: begin m_out = ((a << 1) | m_c) & MASK; m_c = (a >> (W - 1)) & 1; end
      default: begin m_out = a; m_ill = 1; end
    endcase
    m_done = 1;
  endfunction

  always @(posedge clk) begin
    m_done = 0;
    m_ill  = 0;
    if (rst) begin
      m_out = 0; m_hi = 0; m_c = 0; m_cnt = 0;
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_out  = m_prod & MASK;
        m_hi   = (m_prod >> W) & MASK;
        m_c    = (m_hi != 0) ? 1 : 0;
        m_done = 1;
      end
    end else if (bus.Start) begin
      if (int'(bus.OP) == 13) begin
        m_prod = int'(bus.InputA) * int'(bus.InputB);
        m_cnt  = W - 1;
      end else begin
        model_alu(int'(bus.OP), int'(bus.InputA), int'(bus.InputB));
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("out",     32'(bus.Out),     32'(m_out));
      chk("outhi",   32'(bus.OutHi),   32'(m_hi));
      chk("carry",   32'(bus.Carry),   32'(m_c));
      chk("zero",    32'(bus.Zero),    32'((m_out == 0 && m_hi == 0) ? 1 : 0));
      chk("parity",  32'(bus.Parity),  32'($countones(m_out) & 1));
      chk("odd",     32'(bus.Odd),     32'(m_out & 1));
      chk("done",    32'(bus.Done),    32'(m_done));
      chk("illegal", 32'(bus.Illegal), 32'(m_ill));
      chk("busy",    32'(bus.Busy),    32'((m_cnt > 0) ? 1 : 0));
    end
  end

  // Present a request for one cycle; returns at the negedge after its edge.
  task automatic issue(input int op, input int a, input int b);
    @(negedge clk);
    bus.Start  = 1'b1;
    bus.OP     = 4'(op);
    bus.InputA = 8'(a);
    bus.InputB = 8'(b);
    @(negedge clk);
    bus.Start  = 1'b0;
  endtask

  initial begin
    int busy_cycles;
    int done_seen;
    int done_at;

    bus.Start  = 1'b0;
    bus.OP     = '0;
    bus.InputA = '0;
    bus.InputB = '0;

    rst = 1'b1;
    @(posedge clk);
    chk_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_out",   32'(bus.Out),   32'h00);
    chk("rst_zero",  32'(bus.Zero),  32'h1);
    chk("rst_carry", 32'(bus.Carry), 32'h0);
    chk("rst_busy",  32'(bus.Busy),  32'h0);
    chk("rst_done",  32'(bus.Done),  32'h0);

    issue(ADD, 'hF0, 'h20);
    chk("add_out",   32'(bus.Out),   32'h10);
    chk("add_carry", 32'(bus.Carry), 32'h1);
    chk("add_done",  32'(bus.Done),  32'h1);
    issue(ADC, 'h01, 'h00);
    chk("adc_out",   32'(bus.Out),   32'h02);
    chk("adc_carry", 32'(bus.Carry), 32'h0);

    issue(SUB, 'h05, 'h03);
    chk("sub1_out",   32'(bus.Out),   32'hFE);
    chk("sub1_carry", 32'(bus.Carry), 32'h0);
    issue(SUB, 'h03, 'h03);
    chk("sub2_out",   32'(bus.Out),   32'h00);
    chk("sub2_zero",  32'(bus.Zero),  32'h1);
    chk("sub2_carry", 32'(bus.Carry), 32'h1);

    issue(LSL, 'h81, 1);
    chk("lsl_out",   32'(bus.Out),   32'h02);
    chk("lsl_carry", 32'(bus.Carry), 32'h1);
    issue(ROL, 'h81, 0);
    chk("rol_out",   32'(bus.Out),   32'h03);
    chk("rol_carry", 32'(bus.Carry), 32'h1);
    issue(ASR, 'h81, 3);
    chk("asr_out",   32'(bus.Out),   32'hF0);
    chk("asr_carry", 32'(bus.Carry), 32'h0);
    issue(LSR, 'h81, 0);
    chk("lsr0_out",   32'(bus.Out),   32'h81);
    chk("lsr0_carry", 32'(bus.Carry), 32'h0);

    // MUL 0xFF*0xFF with a stray Start (ADD) while busy.
    issue(MUL, 'hFF, 'hFF);
    busy_cycles = 0;
    done_at     = -1;
    for (int i = 0; i < 20; i++) begin
      if (bus.Busy) busy_cycles++;
      if (bus.Done) begin
        done_at = i;
        break;
      end
      bus.Start  = (i == 2);
      bus.OP     = 4'(ADD);
      bus.InputA = 8'h11;
      bus.InputB = 8'h22;
      @(negedge clk);
    end
    bus.Start = 1'b0;
    chk("mul_busy_cycles", 32'(busy_cycles), 32'd7);
    chk("mul_done_cycle",  32'(done_at),     32'd7);
    chk("mul_out",   32'(bus.Out),   32'h01);
    chk("mul_outhi", 32'(bus.OutHi), 32'hFE);
    chk("mul_carry", 32'(bus.Carry), 32'h1);

    // Reset in the middle of a MUL: aborted, no Done.
    issue(MUL, 'h12, 'h34);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_out",   32'(bus.Out),   32'h00);
    chk("abort_outhi", 32'(bus.OutHi), 32'h00);
    chk("abort_busy",  32'(bus.Busy),  32'h0);
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.Done) done_seen++;
      @(negedge clk);
    end
    chk("abort_no_done", 32'(done_seen), 32'd0);

    issue(14, 'h55, 'h00);
    chk("ill_out",  32'(bus.Out),     32'h55);
    chk("ill_flag", 32'(bus.Illegal), 32'h1);
    chk("ill_done", 32'(bus.Done),    32'h1);

    // Randomized traffic, including Start while busy and occasional resets.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      bus.Start  = ($urandom_range(0, 2) != 0);
      bus.OP     = 4'($urandom_range(0, 15));
      bus.InputA = 8'($urandom);
      bus.InputB = 8'($urandom);
      rst        = ($urandom_range(0, 199) == 0);
    end
    @(negedge clk);
    bus.Start = 1'b0;
    rst       = 1'b0;
    for (int i = 0; i < 12; i++) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
